multdiv_divider: RTL and testbench
==================================

# multdiv_divider

Iterative 32-bit signed restoring divider for the multdiv unit; it is the datapath stage that consumes the divide step sequencing. It accepts a one-cycle start pulse with dividend and divisor, runs one quotient bit per clock, and applies the sign correction. It then presents quotient, remainder and exception with a one-cycle ready pulse to the writeback/stall logic.

## Interface
- WIDTH, 32, operand/result width; the step counter is $clog2(WIDTH)+1 bits.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- ctrl_div  in  1  start pulse; operands are sampled on the same edge.
- operand_a  in  WIDTH  dividend, two's complement.
- operand_b  in  WIDTH  divisor, two's complement.
- result  out  WIDTH  quotient, held until the next start.
- remainder  out  WIDTH  remainder, held until the next start.
- exception  out  1  divide-by-zero or overflow; held with the result.
- result_rdy  out  1  single-cycle pulse when result, remainder and exception are valid.
- busy  out  1  high while a division is in progress.

## Operation
- States: IDLE, RUN, FIX. Reset state is IDLE. All outputs reset to 0.
- Start: ctrl_div high at an edge, in any state:
  - latches |A|, |B|, sign_a and sign_b;
  - clears the partial remainder and the step counter;
  - clears result_rdy;
  - goes to RUN, or to FIX with a zero flag if operand_b == 0.
- A start in RUN or FIX aborts the current division silently. No result_rdy is produced for the aborted operation.
- RUN, each edge:
  - shift {rem, quo} left by 1, bringing in the MSB of the dividend;
  - trial = rem − |B| at WIDTH+1 bits;
  - if trial is non-negative, rem = trial and quo LSB = 1; otherwise rem is kept and quo LSB = 0.
  - The counter increments. After the WIDTH-th iteration the next state is FIX.
- FIX, one edge:
  - quotient is negated if sign_a XOR sign_b;
  - remainder takes the sign of the dividend;
  - result, remainder and exception are registered, result_rdy = 1, and the next state is IDLE.
- Divide by zero: result = 0, remainder = 0, exception = 1.
- Overflow, operand_a = 0x8000_0000 and operand_b = 0xFFFF_FFFF: result = 0x8000_0000, remainder = 0, exception = 1.
- Magnitude of 0x8000_0000 is taken as the unsigned value 2^31. The WIDTH+1-bit trial subtraction makes this exact.
- Division of 0 by a non-zero divisor: result 0, remainder 0, exception 0, normal latency.
- busy = (state != IDLE).

## Timing
- ctrl_div sampled at edge 0. RUN iterations occur at edges 1..32. FIX occurs at edge 33.
- result_rdy is high between edges 33 and 34, giving a latency of 33 clocks.
- Divide by zero: FIX at edge 1, so result_rdy is high between edges 1 and 2.
- result_rdy is never high for two consecutive cycles.
- A start coincident with FIX wins: no result_rdy, and the new operation begins.
- A start in the cycle result_rdy is high is legal. result/remainder hold their values until the FIX of the new operation.
- reset_n low at any time forces IDLE immediately, asynchronously. All outputs go to 0 and no result_rdy follows deassertion.
- reset_n deassertion is synchronised externally. The first start is accepted on the first edge after release.

## Structure
- The shared multdiv package holds:
  - the state enum (IDLE, RUN, FIX);
  - WIDTH;
  - the constants INT_MIN = 0x8000_0000 and NEG_ONE = all-ones, shared with the multiplier.
- Sub-module div_step_counter: 6-bit counter with a synchronous clear on start, an enable in RUN, a terminal flag at WIDTH−1, and asynchronous reset_n.
- The datapath (remainder/quotient shift register, trial subtractor, sign fix) stays in this module.

## Test plan
- 100 / 7 → result_rdy after edge 33, result 14, remainder 2, exception 0, busy low from edge 33.
- −100 / 7 → result −14 (0xFFFF_FFF2), remainder −2; 100 / −7 → result −14, remainder 2.
- 5 / 0 → result_rdy after edge 1, result 0, remainder 0, exception 1.
- 0x8000_0000 / −1 → result 0x8000_0000, exception 1. 0x8000_0000 / 1 → result 0x8000_0000, exception 0.
- Start 1000 / 3, restart with 9 / 3 at iteration 10 → exactly one result_rdy, 33 edges after the restart, with result 3 and remainder 0.
- reset_n low at iteration 5 → all outputs 0 and state IDLE at once. After release, with no further stimulus, no result_rdy occurs within 40 cycles.

Source files
------------

// File: rtl/multdiv_divider_pkg.sv
// Shared multdiv definitions: operand width, divider FSM states and the
// boundary constants also used by the multiplier.
package multdiv_divider_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] NEG_ONE = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } div_state_e;

endpackage

// File: rtl/multdiv_divider_div_step_counter.sv
// Iteration counter for the divider: cleared on start, advances in RUN and
// flags the last quotient bit.
module div_step_counter #(
    parameter int unsigned CNT_W = 6,
    parameter int unsigned LAST  = 31
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == CNT_W'(LAST));

endmodule

// File: rtl/multdiv_divider.sv
// Iterative signed restoring divider: one quotient bit per clock on operand
// magnitudes, followed by a single sign-correction cycle.
module multdiv_divider
    import multdiv_divider_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             exception,
    output logic             result_rdy,
    output logic             busy
);

    div_state_e state, state_next;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic             sign_a;
    logic             sign_b;
    logic             zero_div;
    logic             overflow;
    logic             terminal;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Negating INT_MIN yields the same bit pattern, read as unsigned 2^31.
    assign a_abs = operand_a[WIDTH-1] ? -operand_a : operand_a;
    assign b_abs = operand_b[WIDTH-1] ? -operand_b : operand_b;

    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};

    assign busy = (state != IDLE);

    div_step_counter #(
        .CNT_W (CNT_W),
        .LAST  (WIDTH - 1)
    ) u_step_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (ctrl_div),
        .enable   ((state == RUN) && !ctrl_div),
        .terminal (terminal)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (ctrl_div) begin
            state_next = (operand_b == '0) ? FIX : RUN;
        end else begin
            case (state)
                RUN:     if (terminal) state_next = FIX;
                FIX:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // A start has priority over RUN/FIX work, which silently aborts them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem        <= '0;
            quo        <= '0;
            divisor    <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            zero_div   <= 1'b0;
            overflow   <= 1'b0;
            result     <= '0;
            remainder  <= '0;
            exception  <= 1'b0;
            result_rdy <= 1'b0;
        end else begin
            result_rdy <= 1'b0;
            if (ctrl_div) begin
                rem      <= '0;
                quo      <= a_abs;
                divisor  <= b_abs;
                sign_a   <= operand_a[WIDTH-1];
                sign_b   <= operand_b[WIDTH-1];
                zero_div <= (operand_b == '0);
                overflow <= (operand_a == INT_MIN) && (operand_b == NEG_ONE);
            end else begin
                case (state)
                    RUN: begin
                        rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    end
                    FIX: begin
                        if (zero_div) begin
                            result    <= '0;
                            remainder <= '0;
                        end else begin
                            result    <= (sign_a ^ sign_b) ? -quo : quo;
                            remainder <= sign_a ? -rem : rem;
                        end
                        exception  <= zero_div | overflow;
                        result_rdy <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_divider.sv
// Directed bench for multdiv_divider: a vector table of signed divisions plus
// restart, start-in-FIX, start-on-ready and mid-operation reset sequences.
module tb_multdiv_divider;

    logic        clock;
    logic        reset_n;
    logic        ctrl_div;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] result;
    logic [31:0] remainder;
    logic        exception;
    logic        result_rdy;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    multdiv_divider dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ctrl_div   (ctrl_div),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .result     (result),
        .remainder  (remainder),
        .exception  (exception),
        .result_rdy (result_rdy),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive a start pulse; returns at the negedge after the sampling edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_div  = 1'b1;
        operand_a = a;
        operand_b = b;
        @(negedge clock);
        ctrl_div  = 1'b0;
    endtask

    // Observe 40 cycles after the start edge: first ready edge, pulse count, busy then.
    task automatic watch(output int lat, output int pulses, output logic busy_at);
        lat     = -1;
        pulses  = 0;
        busy_at = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (result_rdy) begin
                pulses++;
                if (lat < 0) begin
                    lat     = n;
                    busy_at = busy;
                end
            end
        end
    endtask

    int   lat;
    int   pulses;
    logic busy_at;
    bit   seen;

    initial begin
        vecs[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33};
        vecs[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33};
        vecs[2]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 33};
        vecs[3]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 33};
        vecs[4]  = '{32'd5,        32'd0,        32'd0,        32'd0,        1'b1, 1};
        vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b1, 33};
        vecs[6]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0, 33};
        vecs[7]  = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 33};
        vecs[8]  = '{32'd7,        32'd100,      32'd0,        32'd7,        1'b0, 33};
        vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 33};
        vecs[10] = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0, 33};
        vecs[11] = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0, 33};
        vecs[12] = '{32'hFFFFFFF9, 32'd0,        32'd0,        32'd0,        1'b1, 1};

        reset_n   = 1'b0;
        ctrl_div  = 1'b0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(negedge clock);
        chk("reset result",     result,            32'd0);
        chk("reset remainder",  remainder,         32'd0);
        chk("reset exception",  {31'd0, exception}, 32'd0);
        chk("reset result_rdy", {31'd0, result_rdy}, 32'd0);
        chk("reset busy",       {31'd0, busy},      32'd0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d busy after start", i), {31'd0, busy}, 32'd1);
            watch(lat, pulses, busy_at);
            chk($sformatf("v%0d latency", i),   lat,                   vecs[i].lat);
            chk($sformatf("v%0d pulses", i),    pulses,                32'd1);
            chk($sformatf("v%0d busy at rdy", i), {31'd0, busy_at},    32'd0);
            chk($sformatf("v%0d result", i),    result,                vecs[i].q);
            chk($sformatf("v%0d remainder", i), remainder,             vecs[i].r);
            chk($sformatf("v%0d exception", i), {31'd0, exception},    {31'd0, vecs[i].exc});
        end

        // Restart mid-RUN: only the second operation completes.
        start_op(32'd1000, 32'd3);
        repeat (9) @(negedge clock);
        start_op(32'd9, 32'd3);
        watch(lat, pulses, busy_at);
        chk("restart latency",   lat,       32'd33);
        chk("restart pulses",    pulses,    32'd1);
        chk("restart result",    result,    32'd3);
        chk("restart remainder", remainder, 32'd0);

        // Start coincident with FIX: the old result must never be written.
        start_op(32'd100, 32'd7);
        repeat (31) @(negedge clock);
        start_op(32'd20, 32'd6);
        chk("fixabort rdy",       {31'd0, result_rdy}, 32'd0);
        chk("fixabort remainder", remainder,           32'd0);
        chk("fixabort busy",      {31'd0, busy},       32'd1);
        watch(lat, pulses, busy_at);
        chk("fixabort latency",   lat,       32'd33);
        chk("fixabort pulses",    pulses,    32'd1);
        chk("fixabort result",    result,    32'd3);
        chk("fixabort rem",       remainder, 32'd2);

        // Start in the ready cycle: outputs hold until the new FIX.
        start_op(32'd50, 32'd7);
        seen = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clock);
            if (result_rdy) seen = 1'b1;
        end
        chk("rdystart seen", {31'd0, seen}, 32'd1);
        ctrl_div  = 1'b1;
        operand_a = 32'd9;
        operand_b = 32'd4;
        @(negedge clock);
        ctrl_div  = 1'b0;
        chk("rdystart rdy low",    {31'd0, result_rdy}, 32'd0);
        chk("rdystart busy",       {31'd0, busy},       32'd1);
        chk("rdystart held q",     result,              32'd7);
        chk("rdystart held r",     remainder,           32'd1);
        watch(lat, pulses, busy_at);
        chk("rdystart latency",    lat,       32'd33);
        chk("rdystart pulses",     pulses,    32'd1);
        chk("rdystart result",     result,    32'd2);
        chk("rdystart remainder",  remainder, 32'd1);

        // Asynchronous reset during RUN.
        start_op(32'd1000, 32'd3);
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midreset result",     result,              32'd0);
        chk("midreset remainder",  remainder,           32'd0);
        chk("midreset exception",  {31'd0, exception},  32'd0);
        chk("midreset result_rdy", {31'd0, result_rdy}, 32'd0);
        chk("midreset busy",       {31'd0, busy},       32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        watch(lat, pulses, busy_at);
        chk("postreset pulses", pulses,        32'd0);
        chk("postreset busy",   {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
